dmem_lsu: RTL and testbench

//  Next-generation MEM stage: data RAM plus MEM/WB pipeline register, extended with
//  RV32I byte/half/word loads and stores (funct3), sign/zero extension, alignment
//  and range fault detection, and a programmable wait-state FSM that stalls upstream.

---
 rtl/dmem_lsu_pkg.sv | 18 +
 rtl/dmem_lsu_if.sv | 38 +++
 rtl/dmem_lsu_align.sv | 65 ++++++
 rtl/dmem_lsu.sv | 145 ++++++++++++++
 tb/tb_dmem_lsu.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared constants and types for the MEM-stage load/store unit:
// RV32I funct3 size codes, wait-state FSM encoding and counter width.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// EX/MEM -> MEM/WB bus of the load/store unit; the pipeline (master) drives
// the ExMem_* fields, the LSU (slave) returns stall and the MemWb_* fields.
interface dmem_lsu_if;
    logic        ExMem_Valid;
    logic [31:0] ExMem_AluResult;
    logic [31:0] ExMem_StoreData;
    logic [31:0] ExMem_AluB_Pc4;
    logic        ExMem_MemRead;
    logic        ExMem_MemWrite;
    logic [2:0]  ExMem_Funct3;
    logic        ExMem_MemToReg;
    logic [4:0]  ExMem_RegRd;
    logic        ExMem_RegWrite;
    logic        Mem_Stall;
    logic        MemWb_Valid;
    logic [31:0] MemWb_MemRData;
    logic [31:0] MemWb_AluB_Pc4;
    logic        MemWb_MemToReg;
    logic [4:0]  MemWb_RegRd;
    logic        MemWb_RegWrite;
    logic        MemWb_Fault;

    modport master (
        output ExMem_Valid, ExMem_AluResult, ExMem_StoreData, ExMem_AluB_Pc4,
               ExMem_MemRead, ExMem_MemWrite, ExMem_Funct3, ExMem_MemToReg,
               ExMem_RegRd, ExMem_RegWrite,
        input  Mem_Stall, MemWb_Valid, MemWb_MemRData, MemWb_AluB_Pc4,
               MemWb_MemToReg, MemWb_RegRd, MemWb_RegWrite, MemWb_Fault
    );

    modport slave (
        input  ExMem_Valid, ExMem_AluResult, ExMem_StoreData, ExMem_AluB_Pc4,
               ExMem_MemRead, ExMem_MemWrite, ExMem_Funct3, ExMem_MemToReg,
               ExMem_RegRd, ExMem_RegWrite,
        output Mem_Stall, MemWb_Valid, MemWb_MemRData, MemWb_AluB_Pc4,
               MemWb_MemToReg, MemWb_RegRd, MemWb_RegWrite, MemWb_Fault
    );
endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: store byte-enables and replicated write data,
// load lane select with sign/zero extension, misalign and illegal-funct3 flags.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [31:0] shifted_s;

    // Decode access size into lanes, extended load data and legality flags
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = 32'h0000_0000;
        ldata_o    = 32'h0000_0000;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        shifted_s  = rdata_word_i >> {addr_i, 3'b000};
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{store_data_i[7:0]}};
                ldata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            F3_BU: begin
                ldata_o = {24'h00_0000, shifted_s[7:0]};
            end
            F3_H: begin
                be_o       = 4'b0011 << {addr_i[1], 1'b0};
                wdata_o    = {2{store_data_i[15:0]}};
                ldata_o    = {{16{shifted_s[15]}}, shifted_s[15:0]};
                misalign_o = addr_i[0];
            end
            F3_HU: begin
                ldata_o    = {16'h0000, shifted_s[15:0]};
                misalign_o = addr_i[0];
            end
            F3_W: begin
                be_o       = 4'b1111;
                wdata_o    = store_data_i;
                ldata_o    = rdata_word_i;
                misalign_o = (addr_i != 2'b00);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
        // unsigned variants exist only for loads
        if (is_store_i && funct3_i[2]) begin
            illegal_o = 1'b1;
        end else begin
            illegal_o = illegal_o;
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM stage: data RAM, fault detection, wait-state FSM that stalls upstream,
// and the MEM/WB pipeline register.
module dmem_lsu
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic       clk,
    input logic       rst,
    dmem_lsu_if.slave lsu_bus
);

    localparam int AW       = $clog2(DEPTH_WORDS);
    localparam bit HAS_WAIT = (WAIT_STATES != 0);

    logic [31:0]           mem_q [DEPTH_WORDS];
    lsu_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    logic          access_s, fault_s, ok_access_s, stall_s, range_s;
    logic          misalign_s, illegal_s, commit_store_s, load_ok_s;
    logic [AW-1:0] word_idx_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s, ldata_s, rword_s;

    logic        valid_q, regwrite_q, fault_q, memtoreg_q;
    logic [31:0] rdata_q, alub_q;
    logic [4:0]  regrd_q;

    assign access_s    = lsu_bus.ExMem_Valid & (lsu_bus.ExMem_MemRead | lsu_bus.ExMem_MemWrite);
    assign word_idx_s  = lsu_bus.ExMem_AluResult[AW+1:2];
    assign range_s     = |(lsu_bus.ExMem_AluResult >> (AW + 2));
    assign rword_s     = mem_q[word_idx_s];
    assign fault_s     = access_s & ((lsu_bus.ExMem_MemRead & lsu_bus.ExMem_MemWrite)
                                     | range_s | misalign_s | illegal_s);
    assign ok_access_s = access_s & ~fault_s;
    assign load_ok_s   = ok_access_s & lsu_bus.ExMem_MemRead;
    assign commit_store_s = ok_access_s & lsu_bus.ExMem_MemWrite & ~stall_s & ~rst;

    lsu_align u_align (
        .addr_i       (lsu_bus.ExMem_AluResult[1:0]),
        .funct3_i     (lsu_bus.ExMem_Funct3),
        .is_store_i   (lsu_bus.ExMem_MemWrite),
        .store_data_i (lsu_bus.ExMem_StoreData),
        .rdata_word_i (rword_s),
        .be_o         (be_s),
        .wdata_o      (wdata_s),
        .ldata_o      (ldata_s),
        .misalign_o   (misalign_s),
        .illegal_o    (illegal_s)
    );

    // Wait-state FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= WAIT_CNT_W'(0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wait-state FSM next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (HAS_WAIT && ok_access_s) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != WAIT_CNT_W'(0)) begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = WAIT_CNT_W'(0);
            end
        endcase
    end

    // Stall output: raised on entry and held until the release cycle
    always_comb begin
        stall_s = 1'b0;
        if (rst || !HAS_WAIT) begin
            stall_s = 1'b0;
        end else if (state_q == IDLE) begin
            stall_s = ok_access_s;
        end else begin
            stall_s = (cnt_q != WAIT_CNT_W'(0));
        end
    end

    // Data RAM byte-lane write; contents survive reset
    always_ff @(posedge clk) begin
        if (commit_store_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[word_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // MEM/WB pipeline register; stall and empty slots load a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || stall_s || !lsu_bus.ExMem_Valid) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            fault_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            alub_q     <= 32'h0000_0000;
            regrd_q    <= 5'd0;
        end else begin
            valid_q    <= 1'b1;
            regwrite_q <= lsu_bus.ExMem_RegWrite & ~fault_s;
            fault_q    <= fault_s;
            memtoreg_q <= lsu_bus.ExMem_MemToReg;
            rdata_q    <= load_ok_s ? ldata_s : 32'h0000_0000;
            alub_q     <= lsu_bus.ExMem_AluB_Pc4;
            regrd_q    <= lsu_bus.ExMem_RegRd;
        end
    end

    assign lsu_bus.Mem_Stall      = stall_s;
    assign lsu_bus.MemWb_Valid    = valid_q;
    assign lsu_bus.MemWb_MemRData = rdata_q;
    assign lsu_bus.MemWb_AluB_Pc4 = alub_q;
    assign lsu_bus.MemWb_MemToReg = memtoreg_q;
    assign lsu_bus.MemWb_RegRd    = regrd_q;
    assign lsu_bus.MemWb_RegWrite = regwrite_q;
    assign lsu_bus.MemWb_Fault    = fault_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table and random ops on a zero-wait
// instance against a byte-array model, plus stall/reset sequences on a 3-wait one.
module tb_dmem_lsu;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    logic        ex_valid = 1'b0, ex_rd = 1'b0, ex_wr = 1'b0, ex_m2r = 1'b0, ex_rw = 1'b0;
    logic [2:0]  ex_f3 = 3'd0;
    logic [31:0] ex_addr = 32'd0, ex_sd = 32'd0, ex_alub = 32'd0;
    logic [4:0]  ex_rdx = 5'd0;

    dmem_lsu_if if0 ();
    dmem_lsu_if if3 ();

    assign if0.ExMem_Valid = ex_valid;      assign if3.ExMem_Valid = ex_valid;
    assign if0.ExMem_AluResult = ex_addr;   assign if3.ExMem_AluResult = ex_addr;
    assign if0.ExMem_StoreData = ex_sd;     assign if3.ExMem_StoreData = ex_sd;
    assign if0.ExMem_AluB_Pc4 = ex_alub;    assign if3.ExMem_AluB_Pc4 = ex_alub;
    assign if0.ExMem_MemRead = ex_rd;       assign if3.ExMem_MemRead = ex_rd;
    assign if0.ExMem_MemWrite = ex_wr;      assign if3.ExMem_MemWrite = ex_wr;
    assign if0.ExMem_Funct3 = ex_f3;        assign if3.ExMem_Funct3 = ex_f3;
    assign if0.ExMem_MemToReg = ex_m2r;     assign if3.ExMem_MemToReg = ex_m2r;
    assign if0.ExMem_RegRd = ex_rdx;        assign if3.ExMem_RegRd = ex_rdx;
    assign if0.ExMem_RegWrite = ex_rw;      assign if3.ExMem_RegWrite = ex_rw;

    dmem_lsu #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst0), .lsu_bus(if0));
    dmem_lsu #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst3), .lsu_bus(if3));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // byte-addressed reference memory, 4 KiB
    logic [7:0] mem_m [4096];

    function automatic void m_exec(input logic v, input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] sd, output logic ef,
                                   output logic [31:0] ed);
        int size;
        bit legal;
        logic [63:0] val;
        ef = 1'b0;
        ed = 32'd0;
        if (!v || !(rd || wr)) return;
        size = 1 << f3[1:0];
        if (rd) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        else    legal = (f3 <= 3'd2);
        if ((rd && wr) || !legal || (a % size) != 0 || a >= 32'd4096) begin
            ef = 1'b1;
            return;
        end
        if (wr) begin
            for (int k = 0; k < size; k++) mem_m[a + k] = sd[8*k +: 8];
        end else begin
            val = 64'd0;
            for (int k = 0; k < size; k++) val = val | (64'(mem_m[a + k]) << (8 * k));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((64'd1 << (8 * size)) - 64'd1);
            ed = val[31:0];
        end
    endfunction

    typedef struct packed {
        logic        v, rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sd;
        logic        ev;
        logic [31:0] ed;
        logic        ef;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd, input logic ev,
                                input logic [31:0] ed, input logic ef);
        vec_t t;
        t.v = v; t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = a; t.sd = sd;
        t.ev = ev; t.ed = ed; t.ef = ef;
        return t;
    endfunction

    task automatic ws3_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, output int stalls,
                          output logic [31:0] rdata, output logic vld, output logic flt);
        @(negedge clk);
        ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_f3 = f3; ex_addr = a; ex_sd = sd; ex_rw = 1'b1;
        stalls = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (!if3.Mem_Stall) break;
            stalls++;
            @(posedge clk); #1;
            chk("ws3_bubble_valid", 32'(if3.MemWb_Valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rdata = if3.MemWb_MemRData;
        vld   = if3.MemWb_Valid;
        flt   = if3.MemWb_Fault;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    initial begin
        logic ef, vld, flt;
        logic [31:0] ed, rdata;
        int stalls, sel;

        tbl[0]  = mk(1, 0, 1, 3'b010, 32'h40, 32'h1122_3344, 1, 32'h0, 0);
        tbl[1]  = mk(1, 1, 0, 3'b000, 32'h43, 32'h0, 1, 32'h0000_0011, 0);
        tbl[2]  = mk(1, 1, 0, 3'b100, 32'h43, 32'h0, 1, 32'h0000_0011, 0);
        tbl[3]  = mk(1, 1, 0, 3'b000, 32'h41, 32'h0, 1, 32'h0000_0033, 0);
        tbl[4]  = mk(1, 1, 0, 3'b001, 32'h42, 32'h0, 1, 32'h0000_1122, 0);
        tbl[5]  = mk(1, 1, 0, 3'b010, 32'h40, 32'h0, 1, 32'h1122_3344, 0);
        tbl[6]  = mk(1, 0, 1, 3'b010, 32'h10, 32'h80FF_7F00, 1, 32'h0, 0);
        tbl[7]  = mk(1, 1, 0, 3'b000, 32'h12, 32'h0, 1, 32'hFFFF_FFFF, 0);
        tbl[8]  = mk(1, 1, 0, 3'b100, 32'h12, 32'h0, 1, 32'h0000_00FF, 0);
        tbl[9]  = mk(1, 1, 0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFF_80FF, 0);
        tbl[10] = mk(1, 1, 0, 3'b101, 32'h12, 32'h0, 1, 32'h0000_80FF, 0);
        tbl[11] = mk(1, 0, 1, 3'b010, 32'h20, 32'h0, 1, 32'h0, 0);
        tbl[12] = mk(1, 0, 1, 3'b001, 32'h22, 32'hAAAA_5555, 1, 32'h0, 0);
        tbl[13] = mk(1, 1, 0, 3'b010, 32'h20, 32'h0, 1, 32'h5555_0000, 0);
        tbl[14] = mk(1, 0, 1, 3'b000, 32'h21, 32'h1234_56EE, 1, 32'h0, 0);
        tbl[15] = mk(1, 1, 0, 3'b010, 32'h20, 32'h0, 1, 32'h5555_EE00, 0);
        tbl[16] = mk(1, 1, 0, 3'b010, 32'h41, 32'h0, 1, 32'h0, 1);
        tbl[17] = mk(1, 0, 1, 3'b001, 32'h43, 32'hFFFF_FFFF, 1, 32'h0, 1);
        tbl[18] = mk(1, 1, 0, 3'b011, 32'h40, 32'h0, 1, 32'h0, 1);
        tbl[19] = mk(1, 1, 0, 3'b010, 32'h1000, 32'h0, 1, 32'h0, 1);
        tbl[20] = mk(1, 0, 1, 3'b100, 32'h44, 32'hFFFF_FFFF, 1, 32'h0, 1);
        tbl[21] = mk(1, 1, 1, 3'b010, 32'h40, 32'hFFFF_FFFF, 1, 32'h0, 1);
        tbl[22] = mk(1, 1, 0, 3'b010, 32'h40, 32'h0, 1, 32'h1122_3344, 0);
        tbl[23] = mk(1, 0, 0, 3'b010, 32'h41, 32'h0, 1, 32'h0, 0);
        tbl[24] = mk(0, 1, 0, 3'b010, 32'h40, 32'h0, 0, 32'h0, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall0", 32'(if0.Mem_Stall), 32'd0);
        chk("rst_valid0", 32'(if0.MemWb_Valid), 32'd0);
        chk("rst_rdata0", if0.MemWb_MemRData, 32'd0);
        chk("rst_regwr0", 32'(if0.MemWb_RegWrite), 32'd0);
        chk("rst_fault0", 32'(if0.MemWb_Fault), 32'd0);
        chk("rst_stall3", 32'(if3.Mem_Stall), 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;

        // directed table on the zero-wait instance
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            ex_valid = tbl[i].v; ex_rd = tbl[i].rd; ex_wr = tbl[i].wr; ex_f3 = tbl[i].f3;
            ex_addr = tbl[i].addr; ex_sd = tbl[i].sd; ex_rw = 1'b1; ex_m2r = 1'(i);
            ex_alub = 32'hA000_0000 + 32'(i); ex_rdx = 5'(i + 1);
            #1;
            chk("tbl_stall", 32'(if0.Mem_Stall), 32'd0);
            @(posedge clk); #1;
            chk("tbl_valid", 32'(if0.MemWb_Valid), 32'(tbl[i].ev));
            chk("tbl_rdata", if0.MemWb_MemRData, tbl[i].ed);
            chk("tbl_fault", 32'(if0.MemWb_Fault), 32'(tbl[i].ef));
            chk("tbl_regwr", 32'(if0.MemWb_RegWrite), 32'(tbl[i].ev & ~tbl[i].ef));
            if (tbl[i].ev) begin
                chk("tbl_alub", if0.MemWb_AluB_Pc4, 32'hA000_0000 + 32'(i));
                chk("tbl_regrd", 32'(if0.MemWb_RegRd), 32'(i + 1));
                chk("tbl_m2r", 32'(if0.MemWb_MemToReg), 32'(i % 2));
            end
        end

        // seed low 256 bytes, then random ops against the model
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            ex_valid = 1'b1; ex_rd = 1'b0; ex_wr = 1'b1; ex_f3 = 3'b010;
            ex_addr = 32'(4 * w); ex_sd = $urandom;
            m_exec(1'b1, 1'b0, 1'b1, 3'b010, ex_addr, ex_sd, ef, ed);
            @(posedge clk);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            ex_valid = ($urandom_range(0, 9) != 0);
            sel = $urandom_range(0, 9);
            ex_rd = (sel <= 4) || (sel == 9);
            ex_wr = (sel >= 5 && sel <= 7) || (sel == 9);
            ex_f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            if (ex_rd && !ex_wr && $urandom_range(0, 2) == 0) ex_f3 = 3'($urandom_range(4, 5));
            sel = $urandom_range(0, 19);
            ex_addr = (sel == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) :
                      (sel == 1) ? 32'h8000_0000 | 32'($urandom_range(0, 255)) :
                                   32'($urandom_range(0, 255));
            ex_sd = $urandom; ex_rw = 1'($urandom_range(0, 1)); ex_alub = $urandom;
            m_exec(ex_valid, ex_rd, ex_wr, ex_f3, ex_addr, ex_sd, ef, ed);
            @(posedge clk); #1;
            chk("rnd_valid", 32'(if0.MemWb_Valid), 32'(ex_valid));
            chk("rnd_rdata", if0.MemWb_MemRData, ed);
            chk("rnd_fault", 32'(if0.MemWb_Fault), 32'(ef));
            chk("rnd_regwr", 32'(if0.MemWb_RegWrite), 32'(ex_valid & ex_rw & ~ef));
            chk("rnd_stall", 32'(if0.Mem_Stall), 32'd0);
        end

        // three-wait instance: start from a clean FSM
        @(negedge clk);
        ex_valid = 1'b0;
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;

        ws3_op(1'b0, 1'b1, 3'b010, 32'h80, 32'hCAFE_F00D, stalls, rdata, vld, flt);
        chk("ws3_sw_stalls", 32'(stalls), 32'd3);
        chk("ws3_sw_valid", 32'(vld), 32'd1);
        ws3_op(1'b0, 1'b0, 3'b010, 32'h84, 32'h0, stalls, rdata, vld, flt);
        chk("ws3_nop_stalls", 32'(stalls), 32'd0);
        chk("ws3_nop_valid", 32'(vld), 32'd1);
        ws3_op(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, stalls, rdata, vld, flt);
        chk("ws3_lw_stalls", 32'(stalls), 32'd3);
        chk("ws3_lw_rdata", rdata, 32'hCAFE_F00D);
        ws3_op(1'b1, 1'b0, 3'b010, 32'h81, 32'h0, stalls, rdata, vld, flt);
        chk("ws3_flt_stalls", 32'(stalls), 32'd0);
        chk("ws3_flt_fault", 32'(flt), 32'd1);
        ws3_op(1'b0, 1'b1, 3'b000, 32'h82, 32'h0000_0077, stalls, rdata, vld, flt);
        chk("ws3_sb_stalls", 32'(stalls), 32'd3);
        ws3_op(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, stalls, rdata, vld, flt);
        chk("ws3_sb_rdata", rdata, 32'hCA77_F00D);

        // reset during the second stall cycle of a store
        ws3_op(1'b0, 1'b1, 3'b010, 32'h90, 32'h1234_5678, stalls, rdata, vld, flt);
        @(negedge clk);
        ex_valid = 1'b1; ex_rd = 1'b0; ex_wr = 1'b1; ex_f3 = 3'b010;
        ex_addr = 32'h90; ex_sd = 32'hDEAD_BEEF;
        #1;
        chk("ws3_rst_stall1", 32'(if3.Mem_Stall), 32'd1);
        @(posedge clk); #1;
        chk("ws3_rst_stall2", 32'(if3.Mem_Stall), 32'd1);
        rst3 = 1'b1;
        #1;
        chk("ws3_rst_stall_drop", 32'(if3.Mem_Stall), 32'd0);
        ex_valid = 1'b0;
        #1;
        chk("ws3_rst_valid", 32'(if3.MemWb_Valid), 32'd0);
        chk("ws3_rst_regwr", 32'(if3.MemWb_RegWrite), 32'd0);
        chk("ws3_rst_fault", 32'(if3.MemWb_Fault), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        ws3_op(1'b1, 1'b0, 3'b010, 32'h90, 32'h0, stalls, rdata, vld, flt);
        chk("ws3_rst_word", rdata, 32'h1234_5678);
        chk("ws3_rst_lw_stalls", 32'(stalls), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
